worker_sched: RTL and testbench

Sequencer for one worker partition-scoring datapath.
- On a start pulse it walks one batch: VID_WORDS vid words of Q vertices each, NUM_SUB sub-batches per vertex.
- It issues vid, dist and loc SRAM read addresses and marks accumulate windows (first/last) for the worker.
- It arbitrates the worker's result onto the shared next/pro write port with a req/gnt handshake.
- It sits between the batch-level top controller and the worker datapath plus its SRAMs.

---
 rtl/worker_pkg.sv | 23 ++
 rtl/worker_sched_rdpipe.sv | 32 +++
 rtl/worker_sched.sv | 207 ++++++++++++++++++++
 tb/tb_worker_sched.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/worker_pkg.sv
// Shared types and default widths for the worker sequencer slice.
package worker_pkg;

    localparam int Q               = 16;
    localparam int VID_BW          = 16;
    localparam int VID_ADDR_SPACE  = 4;
    localparam int NUM_SUB         = 16;
    localparam int SUB_BW          = 4;
    localparam int DIST_ADDR_SPACE = 16;
    localparam int LOC_ADDR_SPACE  = 4;
    localparam int BATCH_BW        = 8;
    localparam int LANE_BW         = $clog2(Q);

    typedef enum logic [2:0] {
        IDLE,
        VID_RD,
        VID_WAIT,
        SUB,
        DRAIN,
        WB
    } state_t;

endpackage

// File: rtl/worker_sched_rdpipe.sv
// Aligns the dist/loc read strobes with the 1-cycle SRAM latency and marks
// the first and last sub-batch of each vertex's accumulate window.
module worker_sched_rdpipe #(
    parameter int NUM_SUB = worker_pkg::NUM_SUB,
    parameter int SUB_BW  = worker_pkg::SUB_BW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              ren,
    input  logic [SUB_BW-1:0] sub,
    output logic              acc_valid,
    output logic              acc_first,
    output logic              acc_last
);

    localparam logic [SUB_BW-1:0] LAST_SUB = SUB_BW'(NUM_SUB - 1);

    // Flush drops the data beat still in flight so an abort leaves nothing behind.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            acc_valid <= 1'b0;
            acc_first <= 1'b0;
            acc_last  <= 1'b0;
        end else begin
            acc_valid <= ren;
            acc_first <= ren && (sub == '0);
            acc_last  <= ren && (sub == LAST_SUB);
        end
    end

endmodule

// File: rtl/worker_sched.sv
// Batch sequencer for one worker: vid/dist/loc read addressing, accumulate
// windows and the next/pro write handshake. WORKER_SCHED_PERF_EN adds stall_cnt.
module worker_sched #(
    parameter int Q               = worker_pkg::Q,
    parameter int VID_BW          = worker_pkg::VID_BW,
    parameter int VID_ADDR_SPACE  = worker_pkg::VID_ADDR_SPACE,
    parameter int NUM_SUB         = worker_pkg::NUM_SUB,
    parameter int SUB_BW          = worker_pkg::SUB_BW,
    parameter int DIST_ADDR_SPACE = worker_pkg::DIST_ADDR_SPACE,
    parameter int LOC_ADDR_SPACE  = worker_pkg::LOC_ADDR_SPACE,
    parameter int BATCH_BW        = worker_pkg::BATCH_BW
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       abort,
    input  logic [BATCH_BW-1:0]        batch_num,
    input  logic [Q*VID_BW-1:0]        vid_rdata,
    input  logic                       wb_gnt,
    output logic                       busy,
    output logic [BATCH_BW-1:0]        batch_q,
    output logic                       vid_ren,
    output logic [VID_ADDR_SPACE-1:0]  vid_raddr,
    output logic                       dist_ren,
    output logic [DIST_ADDR_SPACE-1:0] dist_raddr,
    output logic                       loc_ren,
    output logic [LOC_ADDR_SPACE-1:0]  loc_raddr,
    output logic [VID_BW-1:0]          vid,
    output logic                       acc_valid,
    output logic                       acc_first,
    output logic                       acc_last,
    output logic                       wb_req,
    output logic [VID_ADDR_SPACE-1:0]  wb_addr,
    output logic [$clog2(Q)-1:0]       wb_lane,
    output logic                       batch_finish
`ifdef WORKER_SCHED_PERF_EN
    ,
    output logic [15:0]                stall_cnt
`endif
);

    import worker_pkg::*;

    localparam int LANE_BW = $clog2(Q);
    localparam int VID_WORDS = 2 ** VID_ADDR_SPACE;
    localparam int VTAG_BW = DIST_ADDR_SPACE - SUB_BW;
    localparam logic [SUB_BW-1:0]         LAST_SUB  = SUB_BW'(NUM_SUB - 1);
    localparam logic [LANE_BW-1:0]        LAST_LANE = LANE_BW'(Q - 1);
    localparam logic [VID_ADDR_SPACE-1:0] LAST_WORD = VID_ADDR_SPACE'(VID_WORDS - 1);

    state_t                      state, state_d;
    logic [VID_ADDR_SPACE-1:0]   word, word_d;
    logic [LANE_BW-1:0]          lane, lane_d;
    logic [SUB_BW-1:0]           sub, sub_d;
    logic [Q*VID_BW-1:0]         vid_word, vid_word_d;
    logic [BATCH_BW-1:0]         batch_d;
    logic                        finish_d;
    logic [VID_BW-1:0]           lane_vid_d;
    logic                        busy_d, vid_ren_d, dist_ren_d, wb_req_d;
    logic [VID_ADDR_SPACE-1:0]   vid_raddr_d, wb_addr_d;
    logic [DIST_ADDR_SPACE-1:0]  dist_raddr_d;
    logic [LOC_ADDR_SPACE-1:0]   loc_raddr_d;
    logic [VID_BW-1:0]           vid_d;
    logic [LANE_BW-1:0]          wb_lane_d;

    // Outputs are computed from the next state so every port comes straight off a flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            word         <= '0;
            lane         <= '0;
            sub          <= '0;
            vid_word     <= '0;
            batch_q      <= '0;
            busy         <= 1'b0;
            vid_ren      <= 1'b0;
            vid_raddr    <= '0;
            dist_ren     <= 1'b0;
            dist_raddr   <= '0;
            loc_ren      <= 1'b0;
            loc_raddr    <= '0;
            vid          <= '0;
            wb_req       <= 1'b0;
            wb_addr      <= '0;
            wb_lane      <= '0;
            batch_finish <= 1'b0;
        end else begin
            state        <= state_d;
            word         <= word_d;
            lane         <= lane_d;
            sub          <= sub_d;
            vid_word     <= vid_word_d;
            batch_q      <= batch_d;
            busy         <= busy_d;
            vid_ren      <= vid_ren_d;
            vid_raddr    <= vid_raddr_d;
            dist_ren     <= dist_ren_d;
            dist_raddr   <= dist_raddr_d;
            loc_ren      <= dist_ren_d;
            loc_raddr    <= loc_raddr_d;
            vid          <= vid_d;
            wb_req       <= wb_req_d;
            wb_addr      <= wb_addr_d;
            wb_lane      <= wb_lane_d;
            batch_finish <= finish_d;
        end
    end

    always_comb begin
        state_d    = state;
        word_d     = word;
        lane_d     = lane;
        sub_d      = sub;
        vid_word_d = vid_word;
        batch_d    = batch_q;
        finish_d   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_d = VID_RD;
                    word_d  = '0;
                    lane_d  = '0;
                    sub_d   = '0;
                    batch_d = batch_num;
                end
            end
            VID_RD:   state_d = VID_WAIT;
            VID_WAIT: begin
                vid_word_d = vid_rdata;
                lane_d     = '0;
                sub_d      = '0;
                state_d    = SUB;
            end
            SUB: begin
                if (sub == LAST_SUB) state_d = DRAIN;
                else                 sub_d   = sub + 1'b1;
            end
            DRAIN:    state_d = WB;
            WB: begin
                if (wb_req && wb_gnt) begin
                    if (lane < LAST_LANE) begin
                        lane_d  = lane + 1'b1;
                        sub_d   = '0;
                        state_d = SUB;
                    end else if (word < LAST_WORD) begin
                        word_d  = word + 1'b1;
                        state_d = VID_RD;
                    end else begin
                        finish_d = 1'b1;
                        state_d  = IDLE;
                    end
                end
            end
            default:  state_d = IDLE;
        endcase
        if (abort) begin
            state_d  = IDLE;
            word_d   = '0;
            lane_d   = '0;
            sub_d    = '0;
            batch_d  = '0;
            finish_d = 1'b0;
        end
    end

    always_comb begin
        lane_vid_d   = vid_word_d[int'(lane_d) * VID_BW +: VID_BW];
        busy_d       = (state_d != IDLE);
        vid_ren_d    = (state_d == VID_RD);
        vid_raddr_d  = vid_ren_d ? word_d : '0;
        dist_ren_d   = (state_d == SUB);
        dist_raddr_d = dist_ren_d ? {lane_vid_d[VTAG_BW-1:0], sub_d} : '0;
        loc_raddr_d  = dist_ren_d ? LOC_ADDR_SPACE'(sub_d) : '0;
        vid_d        = (state_d inside {SUB, DRAIN, WB}) ? lane_vid_d : '0;
        wb_req_d     = (state_d == WB);
        wb_addr_d    = wb_req_d ? word_d : '0;
        wb_lane_d    = wb_req_d ? lane_d : '0;
    end

    worker_sched_rdpipe #(
        .NUM_SUB (NUM_SUB),
        .SUB_BW  (SUB_BW)
    ) u_rdpipe (
        .clk       (clk),
        .rst       (rst),
        .flush     (abort),
        .ren       (dist_ren),
        .sub       (sub),
        .acc_valid (acc_valid),
        .acc_first (acc_first),
        .acc_last  (acc_last)
    );

`ifdef WORKER_SCHED_PERF_EN
    // Counts cycles the result waits for the shared write port in this batch.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (state == IDLE && start && !abort) begin
            stall_cnt <= '0;
        end else if (state == WB && !wb_gnt && stall_cnt != 16'hFFFF) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_worker_sched.sv
// Bench for worker_sched: a 16-sub-batch instance and a 1-sub-batch instance
// checked against a loop-based model of the expected read/write sequence.
module tb_worker_sched;

    localparam int Q    = 2;
    localparam int VBW  = 16;
    localparam int VAS  = 1;
    localparam int VW   = 2 ** VAS;
    localparam int NS_A = 16;
    localparam int NS_B = 1;
    localparam int EXP_CYC_A = 1 + VW * (2 + Q * (NS_A + 2));
    localparam int EXP_CYC_B = 1 + VW * (2 + Q * (NS_B + 2));

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start, abort, gnt_a, gnt_b;
    logic [7:0] batch_num;
    logic [Q*VBW-1:0] vid_mem [VW];
    logic [Q*VBW-1:0] rdata_a, rdata_b;

    logic a_busy, a_vid_ren, a_dist_ren, a_loc_ren, a_acc_valid, a_acc_first, a_acc_last, a_wb_req, a_fin;
    logic [7:0] a_batch_q;
    logic [VAS-1:0] a_vid_raddr, a_wb_addr;
    logic [15:0] a_dist_raddr, a_vid;
    logic [3:0] a_loc_raddr;
    logic a_wb_lane;
    logic b_busy, b_vid_ren, b_dist_ren, b_loc_ren, b_acc_valid, b_acc_first, b_acc_last, b_wb_req, b_fin;
    logic [7:0] b_batch_q;
    logic [VAS-1:0] b_vid_raddr, b_wb_addr;
    logic [15:0] b_dist_raddr, b_vid;
    logic [3:0] b_loc_raddr;
    logic b_wb_lane;
`ifdef WORKER_SCHED_PERF_EN
    logic [15:0] a_stall, b_stall;
`endif

    worker_sched #(.Q(Q), .VID_BW(VBW), .VID_ADDR_SPACE(VAS), .NUM_SUB(NS_A), .SUB_BW(4),
                   .DIST_ADDR_SPACE(16), .LOC_ADDR_SPACE(4), .BATCH_BW(8)) dut_a (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .batch_num(batch_num),
        .vid_rdata(rdata_a), .wb_gnt(gnt_a), .busy(a_busy), .batch_q(a_batch_q),
        .vid_ren(a_vid_ren), .vid_raddr(a_vid_raddr), .dist_ren(a_dist_ren),
        .dist_raddr(a_dist_raddr), .loc_ren(a_loc_ren), .loc_raddr(a_loc_raddr),
        .vid(a_vid), .acc_valid(a_acc_valid), .acc_first(a_acc_first), .acc_last(a_acc_last),
        .wb_req(a_wb_req), .wb_addr(a_wb_addr), .wb_lane(a_wb_lane), .batch_finish(a_fin)
`ifdef WORKER_SCHED_PERF_EN
        , .stall_cnt(a_stall)
`endif
    );

    worker_sched #(.Q(Q), .VID_BW(VBW), .VID_ADDR_SPACE(VAS), .NUM_SUB(NS_B), .SUB_BW(4),
                   .DIST_ADDR_SPACE(16), .LOC_ADDR_SPACE(4), .BATCH_BW(8)) dut_b (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .batch_num(batch_num),
        .vid_rdata(rdata_b), .wb_gnt(gnt_b), .busy(b_busy), .batch_q(b_batch_q),
        .vid_ren(b_vid_ren), .vid_raddr(b_vid_raddr), .dist_ren(b_dist_ren),
        .dist_raddr(b_dist_raddr), .loc_ren(b_loc_ren), .loc_raddr(b_loc_raddr),
        .vid(b_vid), .acc_valid(b_acc_valid), .acc_first(b_acc_first), .acc_last(b_acc_last),
        .wb_req(b_wb_req), .wb_addr(b_wb_addr), .wb_lane(b_wb_lane), .batch_finish(b_fin)
`ifdef WORKER_SCHED_PERF_EN
        , .stall_cnt(b_stall)
`endif
    );

    // vid SRAMs with one cycle of read latency
    always @(posedge clk) begin
        if (a_vid_ren) rdata_a <= vid_mem[a_vid_raddr];
        if (b_vid_ren) rdata_b <= vid_mem[b_vid_raddr];
    end

    int checks = 0;
    int errors = 0;
    int cyc, fin_a, fin_b, fin_cyc_a, fin_cyc_b, b_acc, b_acc_bad, b_gnt;
    logic [31:0] obs_vr[$], exp_vr[$], obs_rd[$], exp_rd[$];
    logic [31:0] obs_acc[$], exp_acc[$], obs_wb[$], exp_wb[$];

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
            $error("[TB] %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic sample();
        if (a_vid_ren) obs_vr.push_back(32'(a_vid_raddr));
        if (a_dist_ren) obs_rd.push_back({12'b0, a_dist_raddr, a_loc_raddr});
        if (a_acc_valid) obs_acc.push_back({30'b0, a_acc_first, a_acc_last});
        if (a_wb_req && gnt_a) obs_wb.push_back({14'b0, a_wb_addr, a_wb_lane, a_vid});
        if (a_fin) begin fin_a++; fin_cyc_a = cyc; end
        if (b_acc_valid) begin
            b_acc++;
            if (!(b_acc_first && b_acc_last)) b_acc_bad++;
        end
        if (b_wb_req && gnt_b) b_gnt++;
        if (b_fin) begin fin_b++; fin_cyc_b = cyc; end
        cyc++;
    endtask

    task automatic applyStimulus(input logic s, input logic ab, input logic [7:0] bn,
                                 input logic ga, input logic gb);
        start = s; abort = ab; batch_num = bn; gnt_a = ga; gnt_b = gb;
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
    endtask

    task automatic clearObs();
        obs_vr.delete(); obs_rd.delete(); obs_acc.delete(); obs_wb.delete();
        cyc = 0; fin_a = 0; fin_b = 0; fin_cyc_a = -1; fin_cyc_b = -1;
        b_acc = 0; b_acc_bad = 0; b_gnt = 0;
    endtask

    // Expected batch for instance A: every word, every lane, every sub-batch in order.
    task automatic buildModel();
        logic [15:0] v;
        exp_vr.delete(); exp_rd.delete(); exp_acc.delete(); exp_wb.delete();
        for (int w = 0; w < VW; w++) begin
            exp_vr.push_back(32'(w));
            for (int l = 0; l < Q; l++) begin
                v = vid_mem[w][l*VBW +: VBW];
                for (int s = 0; s < NS_A; s++) begin
                    exp_rd.push_back({12'b0, v[11:0], 4'(s), 4'(s)});
                    exp_acc.push_back({30'b0, s == 0, s == NS_A - 1});
                end
                exp_wb.push_back({14'b0, 1'(w), 1'(l), v});
            end
        end
    endtask

    task automatic compareQueues(input string tag, input logic [31:0] o[$], input logic [31:0] e[$]);
        checkOutput({tag, "_len"}, o.size(), e.size());
        for (int i = 0; i < o.size() && i < e.size(); i++)
            checkOutput($sformatf("%s[%0d]", tag, i), o[i], e[i]);
    endtask

    task automatic compareAll(input string run);
        compareQueues({run, "_vid_rd"}, obs_vr, exp_vr);
        compareQueues({run, "_dist_loc"}, obs_rd, exp_rd);
        compareQueues({run, "_acc_flags"}, obs_acc, exp_acc);
        compareQueues({run, "_wb"}, obs_wb, exp_wb);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic g, s, found, chk_pending;
        logic [VAS-1:0] prev_addr;
        logic prev_lane;
        int hold_left, stall_exp;

        rst = 1'b1; start = 1'b0; abort = 1'b0; batch_num = 8'h00; gnt_a = 1'b0; gnt_b = 1'b0;
        for (int w = 0; w < VW; w++) vid_mem[w] = $urandom();
        vid_mem[0][15:0] = 16'h0ABC;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_a_ctrl", {a_busy, a_vid_ren, a_dist_ren, a_loc_ren, a_acc_valid,
                    a_acc_first, a_acc_last, a_wb_req, a_fin, a_vid_raddr, a_wb_addr, a_wb_lane}, 32'h0);
        checkOutput("reset_a_data", {a_batch_q, a_dist_raddr, a_loc_raddr}, 32'h0);
        checkOutput("reset_a_vid", 32'(a_vid), 32'h0);
        checkOutput("reset_b_ctrl", {b_busy, b_vid_ren, b_dist_ren, b_loc_ren, b_acc_valid,
                    b_acc_first, b_acc_last, b_wb_req, b_fin, b_vid_raddr, b_wb_addr, b_wb_lane}, 32'h0);
        checkOutput("reset_b_data", {b_batch_q, b_dist_raddr, b_loc_raddr}, 32'h0);
        checkOutput("reset_b_vid", 32'(b_vid), 32'h0);
        rst = 1'b0;

        $display("[TB] run 1: undisturbed batch, grant tied high");
        buildModel();
        clearObs();
        applyStimulus(1'b1, 1'b0, 8'h05, 1'b1, 1'b1);
        for (int i = 0; i < 2000 && fin_a == 0; i++) applyStimulus(1'b0, 1'b0, 8'hEE, 1'b1, 1'b1);
        repeat (5) applyStimulus(1'b0, 1'b0, 8'hEE, 1'b1, 1'b1);
        checkOutput("run1_finish_count", fin_a, 1);
        checkOutput("run1_finish_cycle", fin_cyc_a, EXP_CYC_A);
        checkOutput("run1_batch_q", 32'(a_batch_q), 32'h05);
        compareAll("run1");
        checkOutput("run1_b_finish_count", fin_b, 1);
        checkOutput("run1_b_finish_cycle", fin_cyc_b, EXP_CYC_B);
        checkOutput("run1_b_acc_count", b_acc, VW * Q);
        checkOutput("run1_b_acc_not_first_last", b_acc_bad, 0);
        checkOutput("run1_b_grants", b_gnt, VW * Q);
        checkOutput("run1_b_batch_q", 32'(b_batch_q), 32'h05);
`ifdef WORKER_SCHED_PERF_EN
        checkOutput("run1_stall_cnt_a", 32'(a_stall), 32'h0);
        checkOutput("run1_stall_cnt_b", 32'(b_stall), 32'h0);
`endif

        $display("[TB] run 2: backpressure, stray grants and stray starts");
        clearObs();
        stall_exp = 0;
        hold_left = 5;
        chk_pending = 1'b0;
        prev_addr = '0;
        prev_lane = 1'b0;
        applyStimulus(1'b1, 1'b0, 8'h3C, 1'b0, 1'b1);
        for (int i = 0; i < 4000 && fin_a == 0; i++) begin
            if (chk_pending) begin
                checkOutput("stall_hold", {a_wb_req, a_dist_ren, a_wb_addr, a_wb_lane},
                            {1'b1, 1'b0, prev_addr, prev_lane});
                chk_pending = 1'b0;
            end
            if (a_wb_req) begin
                if (hold_left > 0) begin
                    g = 1'b0;
                    hold_left--;
                    stall_exp++;
                    chk_pending = 1'b1;
                    prev_addr = a_wb_addr;
                    prev_lane = a_wb_lane;
                end else begin
                    g = 1'b1;
                    hold_left = $urandom_range(0, 3);
                end
            end else begin
                g = ($urandom_range(0, 3) == 0);
            end
            s = a_busy && ($urandom_range(0, 7) == 0);
            applyStimulus(s, 1'b0, 8'($urandom()), g, 1'b1);
        end
        checkOutput("run2_finish_count", fin_a, 1);
        checkOutput("run2_finish_cycle", fin_cyc_a, EXP_CYC_A + stall_exp);
        checkOutput("run2_batch_q", 32'(a_batch_q), 32'h3C);
        compareAll("run2");
`ifdef WORKER_SCHED_PERF_EN
        checkOutput("run2_stall_cnt", 32'(a_stall), 32'(stall_exp));
`endif

        $display("[TB] run 3: abort at sub-batch 7");
        clearObs();
        found = 1'b0;
        applyStimulus(1'b1, 1'b0, 8'h77, 1'b1, 1'b1);
        for (int i = 0; i < 200; i++) begin
            if (a_dist_ren && a_loc_raddr == 4'd7) begin
                found = 1'b1;
                break;
            end
            applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        end
        checkOutput("abort_reached_sub7", 32'(found), 32'h1);
        applyStimulus(1'b0, 1'b1, 8'h00, 1'b1, 1'b1);
        checkOutput("abort_outputs", {a_busy, a_vid_ren, a_dist_ren, a_loc_ren, a_acc_valid,
                    a_wb_req, a_fin}, 32'h0);
        repeat (10) applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        checkOutput("abort_no_finish", fin_a, 0);
        checkOutput("abort_stays_idle", 32'(a_busy), 32'h0);

        $display("[TB] run 4: restart after abort");
        clearObs();
        applyStimulus(1'b1, 1'b0, 8'h21, 1'b1, 1'b1);
        for (int i = 0; i < 2000 && fin_a == 0; i++) applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        checkOutput("run4_finish_count", fin_a, 1);
        checkOutput("run4_finish_cycle", fin_cyc_a, EXP_CYC_A);
        checkOutput("run4_batch_q", 32'(a_batch_q), 32'h21);
        compareAll("run4");
`ifdef WORKER_SCHED_PERF_EN
        checkOutput("run4_stall_cnt_cleared", 32'(a_stall), 32'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
